// File: rtl/transpose_seq_ctrl.sv
// Sequencer for a bank of parallel-load transpose FIFOs: one load strobe,
// then diagonally skewed shift enables, with a global stall and a completion pulse.
module transpose_seq_ctrl #(
    parameter int DEPTH    = 8,
    parameter int NUM_FIFO = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    output logic                wr_en,
    output logic [NUM_FIFO-1:0] en,
    output logic [NUM_FIFO-1:0] col_valid,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(DEPTH + NUM_FIFO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH + NUM_FIFO - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cnt_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    state <= DRAIN;
                    cnt   <= '0;
                end
                DRAIN: begin
                    // A stall freezes the drain counter so the skew pattern resumes intact.
                    if (!stall) begin
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign cnt_ext = 32'(cnt);

    // FIFO k shifts during drain steps k .. k+DEPTH-1, giving the diagonal skew.
    always_comb begin
        en = '0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            if ((state == DRAIN) && !stall &&
                (cnt_ext >= 32'(k)) && (cnt_ext < 32'(k + DEPTH))) begin
                en[k] = 1'b1;
            end
        end
    end

    assign col_valid = en;
    assign wr_en     = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_transpose_seq_ctrl.sv
// Scoreboard bench for transpose_seq_ctrl: per-cycle expectations are queued when
// stimulus is driven and compared when outputs are sampled, plus timeline checks.
module tb_transpose_seq_ctrl;

    localparam int DEPTH    = 8;
    localparam int NUM_FIFO = 8;
    localparam int LAST     = DEPTH + NUM_FIFO - 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                stall;
    logic                wr_en;
    logic [NUM_FIFO-1:0] en;
    logic [NUM_FIFO-1:0] col_valid;
    logic                busy;
    logic                done;

    transpose_seq_ctrl #(.DEPTH(DEPTH), .NUM_FIFO(NUM_FIFO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .wr_en     (wr_en),
        .en        (en),
        .col_valid (col_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                wr_en;
        logic [NUM_FIFO-1:0] en;
        logic                busy;
        logic                done;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int fails  = 0;
    int cyc;
    int done_at[$];
    int wr_at[$];
    int ff_at[$];
    int en_cnt[NUM_FIFO];
    int busy_cnt;
    int first_en0;
    int first_enl;

    // Reference sequence: phase 0 idle, 1 load, 2 drain, 3 done; step counts unstalled drain cycles.
    int m_phase = 0;
    int m_step  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic resetCounters();
        cyc       = 0;
        busy_cnt  = 0;
        first_en0 = -1;
        first_enl = -1;
        done_at.delete();
        wr_at.delete();
        ff_at.delete();
        for (int k = 0; k < NUM_FIFO; k++) en_cnt[k] = 0;
    endtask

    task automatic applyStimulus(input logic st, input logic sl, input logic rs);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        start = st;
        stall = sl;
        rst   = rs;

        e.wr_en = (m_phase == 1);
        e.busy  = (m_phase != 0);
        e.done  = (m_phase == 3);
        for (int k = 0; k < NUM_FIFO; k++)
            e.en[k] = (m_phase == 2) && !sl && (m_step >= k) && (m_step < k + DEPTH);
        sb.push_back(e);

        if (rs) begin
            m_phase = 0;
            m_step  = 0;
        end else begin
            case (m_phase)
                0: if (st) m_phase = 1;
                1: begin m_phase = 2; m_step = 0; end
                2: if (!sl) begin
                       if (m_step == LAST) begin m_phase = 3; m_step = 0; end
                       else m_step = m_step + 1;
                   end
                default: m_phase = 0;
            endcase
        end

        @(negedge clk);
        if (wr_en === 1'b1) wr_at.push_back(cyc);
        if (done === 1'b1) done_at.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
        if (en === '1) ff_at.push_back(cyc);
        if (en[0] === 1'b1 && first_en0 < 0) first_en0 = cyc;
        if (en[NUM_FIFO-1] === 1'b1 && first_enl < 0) first_enl = cyc;
        for (int k = 0; k < NUM_FIFO; k++) if (en[k] === 1'b1) en_cnt[k]++;

        got = sb.pop_front();
        checkOutput("wr_en", 32'(wr_en), 32'(got.wr_en));
        checkOutput("en", 32'(en), 32'(got.en));
        checkOutput("col_valid", 32'(col_valid), 32'(got.en));
        checkOutput("busy", 32'(busy), 32'(got.busy));
        checkOutput("done", 32'(done), 32'(got.done));
        cyc++;
    endtask

    task automatic checkEnCounts(input string tag);
        for (int k = 0; k < NUM_FIFO; k++) checkOutput(tag, 32'(en_cnt[k]), 32'(DEPTH));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        stall = 1'b0;

        // Reset with start held, then idle with no start.
        resetCounters();
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_no_load", 32'(wr_at.size()), 32'd0);
        checkOutput("idle_busy", 32'(busy_cnt), 32'd0);

        // Nominal run.
        resetCounters();
        for (int c = 0; c < 20; c++) applyStimulus(c == 0, 1'b0, 1'b0);
        checkOutput("nom_wr_count", 32'(wr_at.size()), 32'd1);
        checkOutput("nom_wr_cycle", 32'(wr_at.size() > 0 ? wr_at[0] : -1), 32'd1);
        checkOutput("nom_en0_first", 32'(first_en0), 32'd2);
        checkOutput("nom_en7_first", 32'(first_enl), 32'd9);
        checkOutput("nom_ff_count", 32'(ff_at.size()), 32'd1);
        checkOutput("nom_ff_cycle", 32'(ff_at.size() > 0 ? ff_at[0] : -1), 32'd9);
        checkOutput("nom_done_cycle", 32'(done_at.size() > 0 ? done_at[0] : -1), 32'd17);
        checkOutput("nom_busy_cycles", 32'(busy_cnt), 32'd17);
        checkEnCounts("nom_en_count");

        // Stall for cycles 5-7.
        resetCounters();
        for (int c = 0; c < 23; c++) applyStimulus(c == 0, (c >= 5 && c <= 7), 1'b0);
        checkOutput("stall_done_cycle", 32'(done_at.size() > 0 ? done_at[0] : -1), 32'd20);
        checkEnCounts("stall_en_count");

        // Start held high across two sequences.
        resetCounters();
        for (int c = 0; c < 40; c++) applyStimulus(c <= 25, 1'b0, 1'b0);
        checkOutput("busy_wr_count", 32'(wr_at.size()), 32'd2);
        checkOutput("busy_wr2_cycle", 32'(wr_at.size() > 1 ? wr_at[1] : -1), 32'd19);
        checkOutput("busy_done_count", 32'(done_at.size()), 32'd2);
        checkOutput("busy_done1", 32'(done_at.size() > 0 ? done_at[0] : -1), 32'd17);
        checkOutput("busy_done2", 32'(done_at.size() > 1 ? done_at[1] : -1), 32'd35);

        // Reset mid-drain, then a fresh sequence.
        resetCounters();
        for (int c = 0; c < 10; c++) applyStimulus(c == 0, 1'b0, c == 6);
        checkOutput("abort_no_done", 32'(done_at.size()), 32'd0);
        checkOutput("abort_en0_count", 32'(en_cnt[0]), 32'd5);
        resetCounters();
        for (int c = 0; c < 20; c++) applyStimulus(c == 0, 1'b0, 1'b0);
        checkOutput("restart_en0_first", 32'(first_en0), 32'd2);
        checkOutput("restart_done_cycle", 32'(done_at.size() > 0 ? done_at[0] : -1), 32'd17);
        checkEnCounts("restart_en_count");

        // Stall held on the final drain step.
        resetCounters();
        for (int c = 0; c < 24; c++) applyStimulus(c == 0, (c >= 16 && c <= 19), 1'b0);
        checkOutput("last_stall_done", 32'(done_at.size() > 0 ? done_at[0] : -1), 32'd21);
        checkEnCounts("last_stall_en_count");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
